// File: rtl/viterbi_decoder_top.sv
// -----------------------------------------------------------------------------
// viterbi_decoder_top
//   Streaming log-domain HMM Viterbi decoder. After start, one initialisation
//   cycle seeds the path metrics from logC and the first observation. Each
//   accepted observation then costs one max-sum recursion step, which also
//   records the surviving predecessor per state. A termination cycle picks the
//   best final state, and a backtrack walks the survivor memory one step per
//   cycle to fill the decoded path.
//
// Ports
//   clk        in   clock, all state on the rising edge
//   rst_n      in   asynchronous reset, active-high despite the name
//   start      in   begin decode (accepted in IDLE/DONE only); obs_in holds obs 0
//   length     in   sequence length T, sampled on start (0 is treated as 1)
//   obs_in     in   observation symbol
//   obs_valid  in   obs_in valid (consumed only in RECURSE)
//   logA       in   I*I signed W-bit entries, entry i*I+j = log P(j | i)
//   logC       in   I signed W-bit entries, initial log-probabilities
//   logB       in   I*K signed W-bit entries, entry i*K+k = log P(k | i)
//   path       out  N entries of $clog2(I) bits, entry t = state at step t
//   done       out  decode finished, path stable
//   valid_out  out  one-cycle pulse in the first DONE cycle
// -----------------------------------------------------------------------------
module viterbi_decoder_top #(
   parameter int N = 8,
   parameter int I = 3,
   parameter int K = 3,
   parameter int W = 20
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [$clog2(N)-1:0]       length,
   input  logic [$clog2(K)-1:0]       obs_in,
   input  logic                       obs_valid,
   input  logic [I*I*W-1:0]           logA,
   input  logic [I*W-1:0]             logC,
   input  logic [I*K*W-1:0]           logB,
   output logic [N*$clog2(I)-1:0]     path,
   output logic                       done,
   output logic                       valid_out
);

   localparam int TW = $clog2(N);
   localparam int SW = $clog2(K);
   localparam int PW = $clog2(I);
   localparam int XW = W + 2;

   // Saturation bounds of the W-bit signed range, expressed at XW bits.
   localparam logic signed [XW-1:0] MAX_X = {3'b000, {(W-1){1'b1}}};
   localparam logic signed [XW-1:0] MIN_X = {3'b111, {(W-1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      INIT    = 3'd1,
      RECURSE = 3'd2,
      TERM    = 3'd3,
      BACK    = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t                 state, state_d;
   logic [TW-1:0]          t;
   logic [TW-1:0]          back_idx;
   logic [TW-1:0]          t_len_q;
   logic [TW-1:0]          t_len_in;
   logic [SW-1:0]          obs0_q;
   logic signed [W-1:0]    delta_q [I];
   logic [PW-1:0]          psi_q   [N][I];
   logic [PW-1:0]          path_q  [N];
   logic                   done_q;
   logic                   valid_q;

   // Unpacked views of the flat probability tables.
   logic signed [W-1:0]    a_m [I][I];
   logic signed [W-1:0]    b_m [I][K];
   logic signed [W-1:0]    c_v [I];

   // Per-state results of one recursion step and of the initial step.
   logic signed [W-1:0]    rec_d  [I];
   logic signed [W-1:0]    init_d [I];
   logic [PW-1:0]          win_i  [I];

   logic signed [W-1:0]    term_v;
   logic [PW-1:0]          term_arg;

   function automatic logic signed [XW-1:0] ext(input logic signed [W-1:0] v);
      return {{2{v[W-1]}}, v};
   endfunction

   function automatic logic signed [W-1:0] sat_w(input logic signed [XW-1:0] v);
      if (v > MAX_X) begin
         return MAX_X[W-1:0];
      end else if (v < MIN_X) begin
         return MIN_X[W-1:0];
      end
      return v[W-1:0];
   endfunction

   assign t_len_in = (length == '0) ? TW'(1) : length;

   generate
      for (genvar gi = 0; gi < I; gi++) begin : g_tab
         assign c_v[gi] = logC[gi*W +: W];
         for (genvar gj = 0; gj < I; gj++) begin : g_a
            assign a_m[gi][gj] = logA[(gi*I+gj)*W +: W];
         end
         for (genvar gk = 0; gk < K; gk++) begin : g_b
            assign b_m[gi][gk] = logB[(gi*K+gk)*W +: W];
         end
      end

      // Add-compare-select per destination state j. The compare runs on the
      // unsaturated XW-bit sums so saturation can never create a false tie;
      // only the final metric is saturated back to W bits.
      for (genvar gj = 0; gj < I; gj++) begin : g_acs
         logic signed [XW-1:0] cand [I];
         logic signed [XW-1:0] bx;
         logic [PW-1:0]        bi;

         for (genvar gi = 0; gi < I; gi++) begin : g_cand
            assign cand[gi] = ext(delta_q[gi]) + ext(a_m[gi][gj]);
         end

         always_comb begin
            bx = cand[0];
            bi = '0;
            for (int i = 1; i < I; i++) begin
               // Strict compare keeps the lowest index on ties.
               if (cand[i] > bx) begin
                  bx = cand[i];
                  bi = PW'(i);
               end
            end
         end

         assign rec_d[gj]  = sat_w(bx + ext(b_m[gj][obs_in]));
         assign win_i[gj]  = bi;
         assign init_d[gj] = sat_w(ext(c_v[gj]) + ext(b_m[gj][obs0_q]));
      end

      for (genvar gi = 0; gi < N; gi++) begin : g_path
         assign path[gi*PW +: PW] = path_q[gi];
      end
   endgenerate

   // Best final state for the termination step, lowest index on ties.
   always_comb begin
      term_v   = delta_q[0];
      term_arg = '0;
      for (int j = 1; j < I; j++) begin
         if (delta_q[j] > term_v) begin
            term_v   = delta_q[j];
            term_arg = PW'(j);
         end
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE, DONE: if (start) state_d = INIT;
         INIT:       state_d = (t_len_q > TW'(1)) ? RECURSE : TERM;
         RECURSE:    if (obs_valid && (t == t_len_q - TW'(1))) state_d = TERM;
         TERM:       state_d = (t_len_q > TW'(1)) ? BACK : DONE;
         BACK:       if (back_idx == TW'(1)) state_d = DONE;
         default:    state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         t        <= '0;
         back_idx <= '0;
         t_len_q  <= TW'(1);
         obs0_q   <= '0;
         done_q   <= 1'b0;
         valid_q  <= 1'b0;
         for (int j = 0; j < I; j++) begin
            delta_q[j] <= '0;
         end
         for (int s = 0; s < N; s++) begin
            path_q[s] <= '0;
            for (int j = 0; j < I; j++) begin
               psi_q[s][j] <= '0;
            end
         end
      end else begin
         // done follows the state register so it rises with the DONE entry.
         done_q  <= (state_d == DONE);
         valid_q <= (state_d == DONE) && (state != DONE);
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  t_len_q  <= t_len_in;
                  obs0_q   <= obs_in;
                  t        <= '0;
                  back_idx <= '0;
                  // Clear so entries beyond T read as 0 after a shorter decode.
                  for (int s = 0; s < N; s++) begin
                     path_q[s] <= '0;
                  end
               end
            end
            INIT: begin
               for (int j = 0; j < I; j++) begin
                  delta_q[j] <= init_d[j];
               end
               t <= TW'(1);
            end
            RECURSE: begin
               if (obs_valid) begin
                  for (int j = 0; j < I; j++) begin
                     delta_q[j]  <= rec_d[j];
                     psi_q[t][j] <= win_i[j];
                  end
                  t <= t + TW'(1);
               end
            end
            TERM: begin
               path_q[t_len_q - TW'(1)] <= term_arg;
               back_idx                 <= t_len_q - TW'(1);
            end
            BACK: begin
               path_q[back_idx - TW'(1)] <= psi_q[back_idx][path_q[back_idx]];
               back_idx                  <= back_idx - TW'(1);
            end
            default: ;
         endcase
      end
   end

   assign done      = done_q;
   assign valid_out = valid_q;

endmodule

// File: tb/tb_viterbi_decoder_top.sv
module tb_viterbi_decoder_top;

   localparam int N  = 8;
   localparam int I  = 3;
   localparam int K  = 3;
   localparam int W  = 20;
   localparam int TW = 3;
   localparam int SW = 2;
   localparam int PW = 2;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b1;
   logic                 start = 1'b0;
   logic [TW-1:0]        length = '0;
   logic [SW-1:0]        obs_in = '0;
   logic                 obs_valid = 1'b0;
   logic [I*I*W-1:0]     logA;
   logic [I*W-1:0]       logC;
   logic [I*K*W-1:0]     logB;
   logic [N*PW-1:0]      path;
   logic                 done;
   logic                 valid_out;

   int total = 0;
   int bad   = 0;

   // Packed expected paths (entry t at bits [2t+1:2t]).
   localparam logic [N*PW-1:0] PATH_S1  = 16'h0250;  // 0,0,1,1,2,0,0,0
   localparam logic [N*PW-1:0] PATH_222 = 16'h002A;  // 2,2,2,0,...
   localparam logic [N*PW-1:0] PATH_T1  = 16'h0002;  // 2,0,...

   always #5 clk = ~clk;

   viterbi_decoder_top #(.N(N), .I(I), .K(K), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .length    (length),
      .obs_in    (obs_in),
      .obs_valid (obs_valid),
      .logA      (logA),
      .logC      (logC),
      .logB      (logB),
      .path      (path),
      .done      (done),
      .valid_out (valid_out)
   );

   task automatic load_tables(input bit uniform);
      logic [W-1:0] v;
      for (int e = 0; e < I*I; e++) begin
         if (uniform)                        v = '0;
         else if (e == 0 || e == 4 || e == 8) v = W'(-10);
         else if (e == 1 || e == 5 || e == 6) v = W'(-50);
         else                                v = W'(-100);
         logA[e*W +: W] = v;
      end
      for (int e = 0; e < I; e++) begin
         if (uniform)     v = '0;
         else if (e == 0) v = W'(-10);
         else             v = W'(-50);
         logC[e*W +: W] = v;
      end
      for (int e = 0; e < I*K; e++) begin
         if (uniform)                        v = '0;
         else if (e == 0 || e == 4 || e == 8) v = W'(-5);
         else                                v = W'(-100);
         logB[e*W +: W] = v;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the DUT in its INIT cycle.
   task automatic start_decode(input int len, input int o0);
      start     = 1'b1;
      length    = TW'(len);
      obs_in    = SW'(o0);
      obs_valid = 1'b1;
      tick();
      start     = 1'b0;
      obs_valid = 1'b0;
   endtask

   // One idle cycle, then a single-cycle obs_valid pulse.
   task automatic feed_gapped(input int sym);
      obs_valid = 1'b0;
      tick();
      obs_in    = SW'(sym);
      obs_valid = 1'b1;
      tick();
      obs_valid = 1'b0;
   endtask

   // T=5, obs 0,0,1,1,2 with obs_valid held high from the INIT cycle on.
   task automatic run_b2b5();
      int seq [4] = '{0, 1, 1, 2};
      start_decode(5, 0);
      obs_valid = 1'b1;
      obs_in    = SW'(seq[0]);
      tick();                        // INIT -> RECURSE, nothing consumed
      for (int k = 0; k < 4; k++) begin
         obs_in = SW'(seq[k]);
         tick();
      end
      obs_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int cycles, output bit ok);
      cycles = 0;
      ok     = 1'b0;
      while (cycles < budget && !ok) begin
         tick();
         cycles++;
         if (done === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      tick();
      tick();
      total++; if (dut.state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", dut.state); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
      total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_out); end
      total++; if (path !== '0) begin bad++; $display("FAIL reset_path: got %h want 0000", path); end
      @(negedge clk);
      rst_n = 1'b0;
      tick();
      $display("test_reset done");
   endtask

   task automatic test_gapped();
      int cyc; bit ok;
      load_tables(1'b0);
      start_decode(5, 0);
      feed_gapped(0);
      feed_gapped(1);
      feed_gapped(1);
      feed_gapped(2);
      wait_done(20, cyc, ok);
      total++; if (!ok) begin bad++; $display("FAIL gapped_done: got done=%b want 1 within 20 cycles", done); end
      total++; if (path !== PATH_S1) begin bad++; $display("FAIL gapped_path: got %h want %h", path, PATH_S1); end
      total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL gapped_valid_first: got %b want 1", valid_out); end
      tick();
      total++; if (valid_out !== 1'b0 || done !== 1'b1) begin bad++; $display("FAIL gapped_hold: got valid=%b done=%b want valid=0 done=1", valid_out, done); end
      $display("test_gapped path=%h", path);
   endtask

   task automatic test_back_to_back();
      int cyc; bit ok;
      run_b2b5();
      total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_done_cleared: got %b want 0", done); end
      wait_done(20, cyc, ok);
      total++; if (!ok || cyc != 5) begin bad++; $display("FAIL b2b_latency: got %0d cycles (ok=%b) want 5", cyc, ok); end
      total++; if (path !== PATH_S1) begin bad++; $display("FAIL b2b_path: got %h want %h", path, PATH_S1); end
      $display("test_back_to_back latency=%0d path=%h", cyc, path);
   endtask

   task automatic test_single();
      int vcount = 0;
      int first  = 0;
      start_decode(1, 2);
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (valid_out === 1'b1) vcount++;
         if (done === 1'b1 && first == 0) first = c;
      end
      total++; if (first != 2) begin bad++; $display("FAIL single_latency: got %0d want 2", first); end
      total++; if (vcount != 1) begin bad++; $display("FAIL single_valid_pulses: got %0d want 1", vcount); end
      total++; if (done !== 1'b1) begin bad++; $display("FAIL single_done: got %b want 1", done); end
      total++; if (path !== PATH_T1) begin bad++; $display("FAIL single_path: got %h want %h", path, PATH_T1); end
      $display("test_single path=%h pulses=%0d", path, vcount);
   endtask

   task automatic test_reset_mid();
      int cyc; bit ok;
      start_decode(5, 0);
      feed_gapped(0);
      total++; if (dut.state !== 3'd2 || dut.t !== 3'd2) begin bad++; $display("FAIL mid_precond: got state=%0d t=%0d want state=2 t=2", dut.state, dut.t); end
      #2;
      rst_n = 1'b1;
      #1;
      total++; if (dut.state !== 3'd0) begin bad++; $display("FAIL mid_state: got %0d want 0", dut.state); end
      total++; if (done !== 1'b0 || path !== '0) begin bad++; $display("FAIL mid_outputs: got done=%b path=%h want done=0 path=0000", done, path); end
      total++; if (dut.t !== 3'd0) begin bad++; $display("FAIL mid_t: got %0d want 0", dut.t); end
      @(negedge clk);
      rst_n = 1'b0;
      tick();
      start_decode(5, 0);
      feed_gapped(0);
      feed_gapped(1);
      feed_gapped(1);
      feed_gapped(2);
      wait_done(20, cyc, ok);
      total++; if (!ok || path !== PATH_S1) begin bad++; $display("FAIL mid_rerun: got done=%b path=%h want done=1 path=%h", ok, path, PATH_S1); end
      $display("test_reset_mid path=%h", path);
   endtask

   task automatic test_start_ignored();
      int cyc; bit ok;
      run_b2b5();                    // now in TERM
      tick();                        // now in BACK
      start     = 1'b1;
      length    = TW'(3);
      obs_in    = SW'(2);
      obs_valid = 1'b1;
      tick();
      start     = 1'b0;
      obs_valid = 1'b0;
      total++; if (dut.state !== 3'd4) begin bad++; $display("FAIL back_start_state: got %0d want 4", dut.state); end
      wait_done(20, cyc, ok);
      total++; if (!ok || path !== PATH_S1) begin bad++; $display("FAIL back_start_path: got done=%b path=%h want done=1 path=%h", ok, path, PATH_S1); end
      start_decode(3, 2);
      feed_gapped(2);
      feed_gapped(2);
      wait_done(20, cyc, ok);
      total++; if (!ok || path !== PATH_222) begin bad++; $display("FAIL done_restart_path: got done=%b path=%h want done=1 path=%h", ok, path, PATH_222); end
      $display("test_start_ignored path=%h", path);
   endtask

   task automatic test_uniform();
      int cyc; bit ok;
      load_tables(1'b1);
      start_decode(4, 2);
      feed_gapped(1);
      feed_gapped(2);
      feed_gapped(1);
      wait_done(20, cyc, ok);
      total++; if (!ok) begin bad++; $display("FAIL uniform_done: got done=%b want 1", done); end
      total++; if (path !== '0) begin bad++; $display("FAIL uniform_path: got %h want 0000", path); end
      $display("test_uniform path=%h", path);
   endtask

   initial begin
      load_tables(1'b0);
      test_reset();
      test_gapped();
      test_back_to_back();
      test_single();
      test_reset_mid();
      test_start_ignored();
      test_uniform();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
